// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler for a single-write-port register file: arbitrates ALU and load
// write-backs through a 1-entry hold buffer and tracks in-flight writes in a busy scoreboard.
module regfile_wb_scheduler #(
   parameter int unsigned NUM_REGS   = 16,
   parameter int unsigned REG_ADDR_W = 4,
   parameter int unsigned DATA_W     = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_alu_wb_valid,
   input  logic [REG_ADDR_W-1:0] i_alu_wb_reg,
   input  logic [DATA_W-1:0]     i_alu_wb_data,
   output logic                  o_alu_wb_ready_c,
   input  logic                  i_mem_wb_valid,
   input  logic [REG_ADDR_W-1:0] i_mem_wb_reg,
   input  logic [DATA_W-1:0]     i_mem_wb_data,
   output logic                  o_mem_wb_ready_c,
   input  logic                  i_issue_valid,
   input  logic [REG_ADDR_W-1:0] i_issue_rs,
   input  logic [REG_ADDR_W-1:0] i_issue_rt,
   input  logic [REG_ADDR_W-1:0] i_issue_rd,
   input  logic                  i_issue_writes_reg,
   output logic                  o_issue_stall_c,
   output logic                  o_write_reg,
   output logic [REG_ADDR_W-1:0] o_rwrite,
   output logic [DATA_W-1:0]     o_write_data,
   output logic [NUM_REGS-1:0]   o_busy_vector,
   output logic                  o_collision_err
);

   logic                  r_hold_valid;
   logic [REG_ADDR_W-1:0] r_hold_reg;
   logic [DATA_W-1:0]     r_hold_data;
   logic                  r_rr_ptr;
   logic                  r_write_reg;
   logic [REG_ADDR_W-1:0] r_rwrite;
   logic [DATA_W-1:0]     r_write_data;
   logic [NUM_REGS-1:0]   r_busy;
   logic                  r_collision;

   logic                  w_alu_rdy, w_mem_rdy, w_alu_acc, w_mem_acc;
   logic                  w_port_valid;
   logic [REG_ADDR_W-1:0] w_port_reg;
   logic [DATA_W-1:0]     w_port_data;
   logic                  w_hold_valid_nxt;
   logic [REG_ADDR_W-1:0] w_hold_reg_nxt;
   logic [DATA_W-1:0]     w_hold_data_nxt;
   logic                  w_rr_nxt;
   logic                  w_stall;
   logic [NUM_REGS-1:0]   w_busy_nxt;

   // With the hold occupied only one newcomer fits; round-robin breaks ties
   always_comb begin
      w_alu_rdy = 1'b1;
      w_mem_rdy = 1'b1;
      w_rr_nxt  = r_rr_ptr;
      if (r_hold_valid) begin
         w_alu_rdy = i_alu_wb_valid & (~i_mem_wb_valid | ~r_rr_ptr);
         w_mem_rdy = i_mem_wb_valid & (~i_alu_wb_valid | r_rr_ptr);
         if (i_alu_wb_valid & i_mem_wb_valid) w_rr_nxt = ~r_rr_ptr;
      end
   end

   assign w_alu_acc = i_alu_wb_valid & w_alu_rdy;
   assign w_mem_acc = i_mem_wb_valid & w_mem_rdy;

   // Port priority hold > MEM > ALU; any accepted request not taking the port lands in the hold
   always_comb begin
      w_port_valid     = 1'b0;
      w_port_reg       = r_rwrite;
      w_port_data      = r_write_data;
      w_hold_valid_nxt = 1'b0;
      w_hold_reg_nxt   = r_hold_reg;
      w_hold_data_nxt  = r_hold_data;
      if (r_hold_valid) begin
         w_port_valid = 1'b1;
         w_port_reg   = r_hold_reg;
         w_port_data  = r_hold_data;
         if (w_mem_acc) begin
            w_hold_valid_nxt = 1'b1;
            w_hold_reg_nxt   = i_mem_wb_reg;
            w_hold_data_nxt  = i_mem_wb_data;
         end else if (w_alu_acc) begin
            w_hold_valid_nxt = 1'b1;
            w_hold_reg_nxt   = i_alu_wb_reg;
            w_hold_data_nxt  = i_alu_wb_data;
         end
      end else if (w_mem_acc) begin
         w_port_valid = 1'b1;
         w_port_reg   = i_mem_wb_reg;
         w_port_data  = i_mem_wb_data;
         if (w_alu_acc) begin
            w_hold_valid_nxt = 1'b1;
            w_hold_reg_nxt   = i_alu_wb_reg;
            w_hold_data_nxt  = i_alu_wb_data;
         end
      end else if (w_alu_acc) begin
         w_port_valid = 1'b1;
         w_port_reg   = i_alu_wb_reg;
         w_port_data  = i_alu_wb_data;
      end
   end

   assign w_stall = i_issue_valid & (r_busy[i_issue_rs] | r_busy[i_issue_rt] |
                                     (i_issue_writes_reg & r_busy[i_issue_rd]));

   // Clear on commit first so a same-register set takes precedence
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_write_reg) w_busy_nxt[r_rwrite] = 1'b0;
      if (i_issue_valid & ~w_stall & i_issue_writes_reg) w_busy_nxt[i_issue_rd] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hold_valid <= 1'b0;
         r_hold_reg   <= '0;
         r_hold_data  <= '0;
         r_rr_ptr     <= 1'b0;
         r_write_reg  <= 1'b0;
         r_rwrite     <= '0;
         r_write_data <= '0;
         r_busy       <= '0;
         r_collision  <= 1'b0;
      end else begin
         r_hold_valid <= w_hold_valid_nxt;
         r_hold_reg   <= w_hold_reg_nxt;
         r_hold_data  <= w_hold_data_nxt;
         r_rr_ptr     <= w_rr_nxt;
         r_write_reg  <= w_port_valid;
         r_rwrite     <= w_port_reg;
         r_write_data <= w_port_data;
         r_busy       <= w_busy_nxt;
         if (w_alu_acc & w_mem_acc & (i_alu_wb_reg == i_mem_wb_reg)) r_collision <= 1'b1;
      end
   end

   assign o_alu_wb_ready_c = w_alu_rdy;
   assign o_mem_wb_ready_c = w_mem_rdy;
   assign o_issue_stall_c  = w_stall;
   assign o_write_reg      = r_write_reg;
   assign o_rwrite         = r_rwrite;
   assign o_write_data     = r_write_data;
   assign o_busy_vector    = r_busy;
   assign o_collision_err  = r_collision;

endmodule
